// File: rtl/exp_sub_sched_if.sv
// Bundle of the signals between the shared 5-bit subtractor scheduler, the FP front ends and the subtractor slice.
// Latency: none (wires only).
// Backpressure: requesters hold req until gnt; results carry no backpressure.
// Ports (signals): fpa_req/fpa_a/fpa_b/fpa_gnt and fpm_req/fpm_a/fpm_b/fpm_gnt (requesters),
//   sub_a/sub_b/sub_bin/sub_d/sub_bout (shared subtractor), res_valid/res_tag/res_d/res_borrow (result).
// Modports: slave = the scheduler, master = the surrounding environment.
interface exp_sub_sched_if;
  logic       fpa_req;
  logic [4:0] fpa_a;
  logic [4:0] fpa_b;
  logic       fpa_gnt;
  logic       fpm_req;
  logic [9:0] fpm_a;
  logic [9:0] fpm_b;
  logic       fpm_gnt;
  logic [4:0] sub_a;
  logic [4:0] sub_b;
  logic       sub_bin;
  logic [4:0] sub_d;
  logic       sub_bout;
  logic       res_valid;
  logic       res_tag;
  logic [9:0] res_d;
  logic       res_borrow;

  modport slave (
    input  fpa_req, fpa_a, fpa_b, fpm_req, fpm_a, fpm_b, sub_d, sub_bout,
    output fpa_gnt, fpm_gnt, sub_a, sub_b, sub_bin, res_valid, res_tag, res_d, res_borrow
  );

  modport master (
    output fpa_req, fpa_a, fpa_b, fpm_req, fpm_a, fpm_b, sub_d, sub_bout,
    input  fpa_gnt, fpm_gnt, sub_a, sub_b, sub_bin, res_valid, res_tag, res_d, res_borrow
  );
endinterface

// File: rtl/exp_sub_sched.sv
// Time-shares one 5-bit borrow-lookahead subtractor between FP adder (5-bit) and FP multiplier (10-bit, two passes).
// Latency: gnt one cycle after the request is sampled; FPA result 2 cycles, FPM result 3 cycles (FPA 3 when swapped).
// Backpressure: requests are sampled only in IDLE and must be held until gnt; results are not backpressured.
// Ports: clk, rst (synchronous, active high); bus (exp_sub_sched_if.slave) carrying both request channels,
//   the shared subtractor operands/results and the tagged result.
// Option: define EXP_SUB_ABS_EN to return |A-B| for FPA ops by re-running a negative difference with swapped operands.
module exp_sub_sched (
  input  logic           clk,
  input  logic           rst,
  exp_sub_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FPA_EX   = 3'd1,
    FPM_LO   = 3'd2,
    FPM_HI   = 3'd3
`ifdef EXP_SUB_ABS_EN
    ,
    FPA_SWAP = 3'd4
`endif
  } state_t;

  state_t     state;
  logic       last_fpm;  // 1 when the multiplier was served most recently
  logic [4:0] hi_a;      // FPM upper operand halves, used in the second pass
  logic [4:0] hi_b;
  logic [4:0] lo_d;      // FPM low half of the difference from the first pass
  logic       pick_fpm;

  // Lone requester wins; on a tie the side not served last wins.
  always_comb begin
    pick_fpm = bus.fpm_req && (!bus.fpa_req || !last_fpm);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_fpm       <= 1'b1;
      hi_a           <= '0;
      hi_b           <= '0;
      lo_d           <= '0;
      bus.fpa_gnt    <= 1'b0;
      bus.fpm_gnt    <= 1'b0;
      bus.sub_a      <= '0;
      bus.sub_b      <= '0;
      bus.sub_bin    <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.res_tag    <= 1'b0;
      bus.res_d      <= '0;
      bus.res_borrow <= 1'b0;
    end else begin
      bus.fpa_gnt   <= 1'b0;
      bus.fpm_gnt   <= 1'b0;
      bus.res_valid <= 1'b0;
      case (state)
        IDLE: begin
          // The subtractor operand registers double as the operand capture,
          // so the slice sees the first pass in the cycle gnt is pulsed.
          if (bus.fpa_req || bus.fpm_req) begin
            bus.sub_bin <= 1'b0;
            if (pick_fpm) begin
              bus.fpm_gnt <= 1'b1;
              last_fpm    <= 1'b1;
              bus.sub_a   <= bus.fpm_a[4:0];
              bus.sub_b   <= bus.fpm_b[4:0];
              hi_a        <= bus.fpm_a[9:5];
              hi_b        <= bus.fpm_b[9:5];
              state       <= FPM_LO;
            end else begin
              bus.fpa_gnt <= 1'b1;
              last_fpm    <= 1'b0;
              bus.sub_a   <= bus.fpa_a;
              bus.sub_b   <= bus.fpa_b;
              state       <= FPA_EX;
            end
          end
        end
        FPA_EX: begin
`ifdef EXP_SUB_ABS_EN
          // Negative difference: rerun as b - a for the magnitude.
          if (bus.sub_bout) begin
            bus.sub_a   <= bus.sub_b;
            bus.sub_b   <= bus.sub_a;
            bus.sub_bin <= 1'b0;
            state       <= FPA_SWAP;
          end else
`endif
          begin
            bus.res_valid  <= 1'b1;
            bus.res_tag    <= 1'b0;
            bus.res_d      <= {5'd0, bus.sub_d};
            bus.res_borrow <= bus.sub_bout;
            bus.sub_a      <= '0;
            bus.sub_b      <= '0;
            bus.sub_bin    <= 1'b0;
            state          <= IDLE;
          end
        end
`ifdef EXP_SUB_ABS_EN
        FPA_SWAP: begin
          bus.res_valid  <= 1'b1;
          bus.res_tag    <= 1'b0;
          bus.res_d      <= {5'd0, bus.sub_d};
          bus.res_borrow <= 1'b1;
          bus.sub_a      <= '0;
          bus.sub_b      <= '0;
          bus.sub_bin    <= 1'b0;
          state          <= IDLE;
        end
`endif
        FPM_LO: begin
          // Low borrow is chained straight into the sub_bin register.
          lo_d        <= bus.sub_d;
          bus.sub_a   <= hi_a;
          bus.sub_b   <= hi_b;
          bus.sub_bin <= bus.sub_bout;
          state       <= FPM_HI;
        end
        FPM_HI: begin
          bus.res_valid  <= 1'b1;
          bus.res_tag    <= 1'b1;
          bus.res_d      <= {bus.sub_d, lo_d};
          bus.res_borrow <= bus.sub_bout;
          bus.sub_a      <= '0;
          bus.sub_b      <= '0;
          bus.sub_bin    <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_sub_sched.sv
// Bench for exp_sub_sched: directed cases, random single ops and random contention against a reference model.
// Latency: n/a (testbench).
// Backpressure: bench requesters hold req until they observe gnt.
module tb_exp_sub_sched;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  exp_sub_sched_if bus ();

  exp_sub_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared 5-bit subtractor slice: the sixth bit of the extended difference is the borrow-out.
  assign {bus.sub_bout, bus.sub_d} = {1'b0, bus.sub_a} - {1'b0, bus.sub_b} - {5'd0, bus.sub_bin};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: result, borrow and request-to-result latency of one operation.
  task automatic ref_op(input bit fpm, input int a, input int b,
                        output int d, output bit bor, output int lat);
    int m;
    m   = fpm ? 1024 : 32;
    bor = (a < b);
    d   = (a - b + m) % m;
    lat = fpm ? 3 : 2;
`ifdef EXP_SUB_ABS_EN
    if (!fpm && bor) begin
      d   = b - a;
      lat = 3;
    end
`endif
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.fpa_req = 1'b0;
    bus.fpm_req = 1'b0;
    bus.fpa_a   = '0;
    bus.fpa_b   = '0;
    bus.fpm_a   = '0;
    bus.fpm_b   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.fpa_gnt", bus.fpa_gnt, 0);
    check("rst.fpm_gnt", bus.fpm_gnt, 0);
    check("rst.res_valid", bus.res_valid, 0);
    check("rst.res_tag", bus.res_tag, 0);
    check("rst.res_d", bus.res_d, 0);
    check("rst.res_borrow", bus.res_borrow, 0);
    check("rst.sub_a", bus.sub_a, 0);
    check("rst.sub_b", bus.sub_b, 0);
    check("rst.sub_bin", bus.sub_bin, 0);
    rst = 1'b0;
  endtask

  // One isolated operation from an idle block, with cycle-exact checks.
  task automatic directed(input bit fpm, input int a, input int b, input string nm);
    int d, lat, n;
    bit bor, seen;
    ref_op(fpm, a, b, d, bor, lat);
    if (fpm) begin
      bus.fpm_req = 1'b1; bus.fpm_a = 10'(a); bus.fpm_b = 10'(b);
    end else begin
      bus.fpa_req = 1'b1; bus.fpa_a = 5'(a); bus.fpa_b = 5'(b);
    end
    @(posedge clk); #1;
    check({nm, ".gnt"}, fpm ? bus.fpm_gnt : bus.fpa_gnt, 1);
    check({nm, ".other_gnt"}, fpm ? bus.fpa_gnt : bus.fpm_gnt, 0);
    bus.fpa_req = 1'b0;
    bus.fpm_req = 1'b0;
    check({nm, ".sub_a1"}, bus.sub_a, a % 32);
    check({nm, ".sub_b1"}, bus.sub_b, b % 32);
    check({nm, ".sub_bin1"}, bus.sub_bin, 0);
    if (fpm) check({nm, ".lo_bout"}, bus.sub_bout, (a % 32) < (b % 32));
    n = 1;
    seen = 1'b0;
    while (!seen && n < 6) begin
      @(posedge clk); #1;
      n++;
      if (fpm && n == 2) begin
        check({nm, ".hi_sub_a"}, bus.sub_a, a / 32);
        check({nm, ".hi_sub_b"}, bus.sub_b, b / 32);
        check({nm, ".hi_sub_bin"}, bus.sub_bin, (a % 32) < (b % 32));
      end
      if (bus.res_valid) seen = 1'b1;
    end
    check({nm, ".latency"}, seen ? n : 99, lat);
    check({nm, ".res_tag"}, bus.res_tag, fpm);
    check({nm, ".res_d"}, bus.res_d, d);
    check({nm, ".res_borrow"}, bus.res_borrow, bor);
    check({nm, ".idle_sub_a"}, bus.sub_a, 0);
    @(posedge clk); #1;
    check({nm, ".valid_drop"}, bus.res_valid, 0);
    check({nm, ".res_hold"}, bus.res_d, d);
  endtask

  // Random requesters against a cycle-level model of arbitration, occupancy and results.
  // Must be entered directly after do_reset.
  task automatic run_random(input int ncyc, input int pct);
    int free_cyc, exp_gnt_cyc, exp_res_cyc, exp_d, lat;
    bit exp_gnt_fpm, exp_tag, exp_bor, last_fpm, w;
    free_cyc    = cyc;
    exp_gnt_cyc = -1;
    exp_res_cyc = -1;
    exp_gnt_fpm = 1'b0;
    exp_tag     = 1'b0;
    exp_bor     = 1'b0;
    exp_d       = 0;
    last_fpm    = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      if (!bus.fpa_req && $urandom_range(99) < pct) begin
        bus.fpa_req = 1'b1; bus.fpa_a = 5'($urandom); bus.fpa_b = 5'($urandom);
      end
      if (!bus.fpm_req && $urandom_range(99) < pct) begin
        bus.fpm_req = 1'b1; bus.fpm_a = 10'($urandom); bus.fpm_b = 10'($urandom);
      end
      if (cyc >= free_cyc && (bus.fpa_req || bus.fpm_req)) begin
        if (bus.fpa_req && bus.fpm_req) w = !last_fpm;
        else w = bus.fpm_req;
        last_fpm    = w;
        exp_gnt_cyc = cyc + 1;
        exp_gnt_fpm = w;
        ref_op(w, w ? int'(bus.fpm_a) : int'(bus.fpa_a), w ? int'(bus.fpm_b) : int'(bus.fpa_b),
               exp_d, exp_bor, lat);
        exp_tag     = w;
        exp_res_cyc = cyc + lat;
        free_cyc    = cyc + lat;
      end
      @(posedge clk); #1;
      check("rnd.fpa_gnt", bus.fpa_gnt, (exp_gnt_cyc == cyc) && !exp_gnt_fpm);
      check("rnd.fpm_gnt", bus.fpm_gnt, (exp_gnt_cyc == cyc) && exp_gnt_fpm);
      check("rnd.res_valid", bus.res_valid, exp_res_cyc == cyc);
      if (exp_res_cyc == cyc) begin
        check("rnd.res_tag", bus.res_tag, exp_tag);
        check("rnd.res_d", bus.res_d, exp_d);
        check("rnd.res_borrow", bus.res_borrow, exp_bor);
      end
      if (bus.fpa_gnt) bus.fpa_req = 1'b0;
      if (bus.fpm_gnt) bus.fpm_req = 1'b0;
    end
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    do_reset();

    directed(1'b0, 20, 7, "fpa_20_7");
    directed(1'b1, 600, 27, "fpm_600_27");
    directed(1'b1, 5, 700, "fpm_5_700");

    // Reset during the second FPM pass drops the op entirely.
    bus.fpm_req = 1'b1; bus.fpm_a = 10'd600; bus.fpm_b = 10'd27;
    @(posedge clk); #1;
    check("mr.gnt", bus.fpm_gnt, 1);
    bus.fpm_req = 1'b0;
    @(posedge clk); #1;
    check("mr.hi_sub_bin", bus.sub_bin, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mr.res_valid", bus.res_valid, 0);
    check("mr.fpm_gnt", bus.fpm_gnt, 0);
    check("mr.fpa_gnt", bus.fpa_gnt, 0);
    check("mr.res_d", bus.res_d, 0);
    check("mr.res_tag", bus.res_tag, 0);
    check("mr.res_borrow", bus.res_borrow, 0);
    check("mr.sub_a", bus.sub_a, 0);
    check("mr.sub_b", bus.sub_b, 0);
    check("mr.sub_bin", bus.sub_bin, 0);
    rst = 1'b0;
    directed(1'b0, 20, 7, "post_rst");

    directed(1'b0, 3, 9, "fpa_3_9");
    directed(1'b0, 31, 0, "fpa_31_0");
    directed(1'b1, 0, 1023, "fpm_0_1023");
    directed(1'b1, 512, 512, "fpm_eq");

    for (int i = 0; i < 16; i++) begin
      bit f;
      f = 1'($urandom);
      directed(f, f ? int'($urandom_range(1023)) : int'($urandom_range(31)),
               f ? int'($urandom_range(1023)) : int'($urandom_range(31)), "rnd_op");
    end

    do_reset();
    run_random(40, 100);
    do_reset();
    run_random(300, 40);
    do_reset();
    run_random(200, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exp_sub_sched.md
# exp_sub_sched

Scheduler that time-shares the single 5-bit borrow-lookahead subtractor slice between the FP adder and the FP multiplier. The adder issues 5-bit exponent-difference requests. The multiplier issues 10-bit subtractions (biased exponent-sum minus bias). The block runs each 10-bit subtraction as two chained 5-bit passes, carrying the borrow between them. It sits between the two FP front ends and the shared subtractor instance, and returns a tagged result.

## Interface
- No parameters; widths are fixed by the 5-bit subtractor slice (5-bit FPA operands, 10-bit FPM operands).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- fpa_req  in  1  FPA request; held with operands until fpa_gnt seen
- fpa_a, fpa_b  in  5  FPA minuend, subtrahend
- fpa_gnt  out  1  one-cycle pulse: FPA operands captured
- fpm_req  in  1  FPM request; held with operands until fpm_gnt seen
- fpm_a, fpm_b  in  10  FPM minuend, subtrahend
- fpm_gnt  out  1  one-cycle pulse: FPM operands captured
- sub_a, sub_b  out  5  operands driven to shared subtractor
- sub_bin  out  1  borrow-in to shared subtractor
- sub_d  in  5  subtractor difference (combinational from sub_a/sub_b/sub_bin)
- sub_bout  in  1  subtractor borrow-out
- res_valid  out  1  one-cycle result pulse; no backpressure
- res_tag  out  1  0 = FPA, 1 = FPM
- res_d  out  10  result; FPA results zero-extended to 10 bits
- res_borrow  out  1  1 when minuend < subtrahend

## Operation
- States: IDLE, FPA_EX, FPM_LO, FPM_HI (plus FPA_SWAP when EXP_SUB_ABS_EN is defined).
- IDLE arbitration: requests are sampled at the clock edge.
  - Only one request pending: that requester wins.
  - Both pending: the requester not served last wins (round robin).
  - The last-served flag resets to FPM, so FPA wins the first tie.
- On acceptance: operands are captured into internal registers, the matching gnt pulses for the next cycle, and the next state is FPA_EX or FPM_LO.
- FPA_EX: drive sub_a = a, sub_b = b, sub_bin = 0. Capture sub_d/sub_bout into the result. Return to IDLE.
- FPM_LO: drive a[4:0], b[4:0], sub_bin = 0. Register sub_d as the low half and sub_bout as the internal borrow. Go to FPM_HI.
- FPM_HI: drive a[9:5], b[9:5], sub_bin = registered low borrow. Result is {hi_d, lo_d} with res_borrow = hi sub_bout. Return to IDLE.
- Arithmetic: res_d = (A − B) mod 2^N, where N = 5 (FPA) or 10 (FPM). res_borrow = (A < B) unsigned.
- In IDLE, sub_a, sub_b and sub_bin are driven to 0.
- Requests arriving while busy wait; they are re-evaluated in the next IDLE cycle.
- Reset values: all outputs 0, state IDLE, last-served = FPM.
- rst mid-operation: the in-flight op is dropped, with no res_valid and no further gnt. The requester must re-request.

## Timing
- Request sampled at edge E.
  - Cycle E+1: gnt = 1 and the op state is active.
  - FPA result: res_valid in cycle E+2.
  - FPM result: res_valid in cycle E+3.
- res_valid is high only during the IDLE cycle after completion. The block may accept a new request in that same cycle.
- Throughput: one FPA op per 2 cycles; one FPM op per 3 cycles.
- gnt is registered. A requester drops or changes req only after seeing gnt. The block never samples req while not in IDLE.
- res_tag, res_d and res_borrow are stable while res_valid = 1; they hold their values afterwards until the next result.

## Configuration
- EXP_SUB_ABS_EN defined:
  - An FPA op with borrow = 1 goes from FPA_EX to FPA_SWAP instead of IDLE.
  - FPA_SWAP drives sub_a = b, sub_b = a, sub_bin = 0. res_d = |A − B|, res_borrow stays 1.
  - FPA latency becomes 3 cycles in this case. FPM is unaffected.
- EXP_SUB_ABS_EN undefined: FPA_SWAP does not exist, and the FPA result is the raw 5-bit two's-complement difference.

## Test plan
- FPA a=20, b=7:
  - fpa_gnt pulses at E+1.
  - At E+2: res_valid=1, tag=0, res_d=13, borrow=0.
- FPM a=600, b=27:
  - FPM_LO: sub_a=24, sub_b=27, bout=1.
  - FPM_HI: sub_bin=1.
  - At E+3: res_d=573, borrow=0, tag=1.
- FPM a=5, b=700 → res_d=329, res_borrow=1.
- fpa_req and fpm_req both held high from reset → service order FPA, FPM, FPA, FPM; res_valid every 2–3 cycles, never two gnt in one cycle.
- FPA a=3, b=9:
  - Without macro: res_d=26, borrow=1 at E+2.
  - With EXP_SUB_ABS_EN: res_d=6, borrow=1 at E+3.
- rst pulsed during FPM_HI → no res_valid; next cycle all outputs 0, state IDLE; a new FPA request completes normally.
